// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared state encoding and parity selectors for the UART TX path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_tx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_mem.sv
// ============================================================================
// Module   : uart_tx_fifo_mem
// Purpose  : Synchronous circular-buffer FIFO with registered full/empty/count.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo_mem #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count,
    output logic [CW-1:0]    o_count_nxt
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_full;
    logic             r_empty;
    logic             w_push_ok;
    logic             w_pop_ok;
    logic [CW-1:0]    w_count_nxt;

    // A full FIFO refuses a push even when a pop frees a slot on the same edge.
    assign w_push_ok   = i_push & ~r_full;
    assign w_pop_ok    = i_pop & ~r_empty;
    assign w_count_nxt = r_count + CW'(w_push_ok) - CW'(w_pop_ok);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_data      = r_mem[r_rd_ptr];
    assign o_full      = r_full;
    assign o_empty     = r_empty;
    assign o_count     = r_count;
    assign o_count_nxt = w_count_nxt;

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Parametrised UART transmitter fed by an integrated TX FIFO.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 868,
    parameter  int DATA_BITS    = 8,
    parameter  int PARITY       = 0,
    parameter  int STOP_BITS    = 1,
    parameter  int FIFO_DEPTH   = 4,
    localparam int CW           = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] d_in,
    input  logic                 load,
    output logic                 ready,
    output logic                 tx_out,
    output logic                 tx_status,
    output logic                 overflow,
    output logic [CW-1:0]        fifo_count
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    uart_tx_state_t       r_state,    w_state_nxt;
    logic [TW-1:0]        r_timer,    w_timer_nxt;
    logic [IW-1:0]        r_bit_idx,  w_bit_idx_nxt;
    logic                 r_stop_cnt, w_stop_cnt_nxt;
    logic [DATA_BITS-1:0] r_shift,    w_shift_nxt;
    logic                 r_parity,   w_parity_nxt;
    logic                 r_tx,       w_tx_nxt;
    logic                 r_overflow;
    logic                 r_tx_status;

    logic                 w_bit_end;
    logic                 w_start_frame;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [DATA_BITS-1:0] w_head;
    logic [CW-1:0]        w_count;
    logic [CW-1:0]        w_count_nxt;

    uart_tx_fifo_mem #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (load),
        .i_data      (d_in),
        .i_pop       (w_pop),
        .o_data      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_count_nxt (w_count_nxt)
    );

    assign w_bit_end = (r_timer == TW'(CLKS_PER_BIT - 1));

    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = w_bit_end ? '0 : r_timer + 1'b1;
        w_bit_idx_nxt  = r_bit_idx;
        w_stop_cnt_nxt = r_stop_cnt;
        w_shift_nxt    = r_shift;
        w_parity_nxt   = r_parity;
        w_tx_nxt       = r_tx;
        w_start_frame  = 1'b0;
        w_pop          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_timer_nxt   = '0;
                w_start_frame = ~w_empty;
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    if (r_bit_idx == IW'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            w_state_nxt = ST_PARITY;
                            w_tx_nxt    = r_parity;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                        w_shift_nxt   = r_shift >> 1;
                        w_tx_nxt      = r_shift[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_stop_cnt == 1'(STOP_BITS - 1)) begin
                        w_start_frame = ~w_empty;
                        w_state_nxt   = ST_IDLE;
                        w_tx_nxt      = 1'b1;
                    end else begin
                        w_stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_tx_nxt    = 1'b1;
            end
        endcase

        // Back-to-back frames reuse this path so there is no idle gap.
        if (w_start_frame) begin
            w_pop          = 1'b1;
            w_state_nxt    = ST_START;
            w_timer_nxt    = '0;
            w_bit_idx_nxt  = '0;
            w_stop_cnt_nxt = 1'b0;
            w_shift_nxt    = w_head;
            w_parity_nxt   = (^w_head) ^ (PARITY == PAR_ODD);
            w_tx_nxt       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_bit_idx   <= '0;
            r_stop_cnt  <= 1'b0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_tx        <= 1'b1;
            r_overflow  <= 1'b0;
            r_tx_status <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_stop_cnt  <= w_stop_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_parity    <= w_parity_nxt;
            r_tx        <= w_tx_nxt;
            r_overflow  <= load & w_full;
            r_tx_status <= (w_state_nxt != ST_IDLE) || (w_count_nxt != '0);
        end
    end

    assign ready      = ~w_full;
    assign tx_out     = r_tx;
    assign tx_status  = r_tx_status;
    assign overflow   = r_overflow;
    assign fifo_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Directed self-checking bench for uart_tx_fifo in four framings.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       ld0 = 1'b0, ld1 = 1'b0, ld2 = 1'b0, ld3 = 1'b0;
    logic [7:0] d0 = '0, d1 = '0, d2 = '0;
    logic [6:0] d3 = '0;
    logic       rdy0, rdy1, rdy2, rdy3;
    logic       tx0, tx1, tx2, tx3;
    logic       st0, st1, st2, st3;
    logic       ov0, ov1, ov2, ov3;
    logic [2:0] cnt0, cnt1, cnt2, cnt3;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .rst(rst), .d_in(d0), .load(ld0), .ready(rdy0),
        .tx_out(tx0), .tx_status(st0), .overflow(ov0), .fifo_count(cnt0));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk(clk), .rst(rst), .d_in(d1), .load(ld1), .ready(rdy1),
        .tx_out(tx1), .tx_status(st1), .overflow(ov1), .fifo_count(cnt1));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
        .clk(clk), .rst(rst), .d_in(d2), .load(ld2), .ready(rdy2),
        .tx_out(tx2), .tx_status(st2), .overflow(ov2), .fifo_count(cnt2));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
        .clk(clk), .rst(rst), .d_in(d3), .load(ld3), .ready(rdy3),
        .tx_out(tx3), .tx_status(st3), .overflow(ov3), .fifo_count(cnt3));

    int   sel = 0;
    logic w_tx, w_st;
    always_comb begin
        w_tx = tx0;
        w_st = st0;
        case (sel)
            1:       begin w_tx = tx1; w_st = st1; end
            2:       begin w_tx = tx2; w_st = st2; end
            3:       begin w_tx = tx3; w_st = st3; end
            default: begin w_tx = tx0; w_st = st0; end
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input int s, input logic [8:0] d);
        @(negedge clk);
        case (s)
            1:       begin ld1 = 1'b1; d1 = d[7:0]; end
            2:       begin ld2 = 1'b1; d2 = d[7:0]; end
            3:       begin ld3 = 1'b1; d3 = d[6:0]; end
            default: begin ld0 = 1'b1; d0 = d[7:0]; end
        endcase
        @(negedge clk);
        ld0 = 1'b0; ld1 = 1'b0; ld2 = 1'b0; ld3 = 1'b0;
    endtask

    // Called at the negedge right after the load edge; frame[i] is bit i in line order.
    task automatic check_frame(input string tag, input logic [15:0] frame, input int nbits);
        logic [15:0] obs;
        int          hold_err;
        int          st_err;
        obs      = '0;
        hold_err = 0;
        st_err   = 0;
        chk({tag, " idle before pop"}, 32'(w_tx), 32'd1);
        chk({tag, " status at load"}, 32'(w_st), 32'd1);
        for (int c = 0; c < nbits * CPB; c++) begin
            @(negedge clk);
            if (c % CPB == 0) obs[c / CPB] = w_tx;
            else if (w_tx !== obs[c / CPB]) hold_err++;
            if (w_st !== 1'b1) st_err++;
        end
        chk({tag, " bits"}, 32'(obs), 32'(frame));
        chk({tag, " bit hold"}, 32'(hold_err), 32'd0);
        chk({tag, " status in frame"}, 32'(st_err), 32'd0);
        @(negedge clk);
        chk({tag, " idle after"}, 32'(w_tx), 32'd1);
        chk({tag, " status after"}, 32'(w_st), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [199:0] stream;
        logic [9:0]   fr;
        int           mism, ovf_n, ovf_at, peak, st_low;
        logic         tx_c0, rdy_c4, rdy_c40, rdy_c42, tx_end, st_end;

        // Reset with a concurrent load that must be ignored.
        ld0 = 1'b1; d0 = 8'hFF;
        repeat (3) @(negedge clk);
        chk("rst tx_out", 32'(tx0), 32'd1);
        chk("rst tx_status", 32'(st0), 32'd0);
        chk("rst ready", 32'(rdy0), 32'd1);
        chk("rst fifo_count", 32'(cnt0), 32'd0);
        chk("rst overflow", 32'(ov0), 32'd0);
        rst = 1'b0; ld0 = 1'b0;
        @(negedge clk);
        chk("load during rst dropped", 32'(cnt0), 32'd0);

        sel = 0; send(0, 9'h0A5); check_frame("8N1 A5", 16'({1'b1, 8'hA5, 1'b0}), 10);
        sel = 1; send(1, 9'h007); check_frame("8E1 07", 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11);
        sel = 2; send(2, 9'h007); check_frame("8O1 07", 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11);
        sel = 3; send(3, 9'h055); check_frame("7N2 55", 16'({2'b11, 7'h55, 1'b0}), 10);

        // Six loads on consecutive edges into a depth-4 FIFO.
        sel = 0;
        for (int f = 0; f < 5; f++) begin
            fr = {1'b1, 8'(f + 1), 1'b0};
            for (int b = 0; b < 10; b++) stream[f * 10 + b] = fr[b];
        end
        mism = 0; ovf_n = 0; ovf_at = -1; peak = 0; st_low = 0;
        tx_c0 = 1'b0; rdy_c4 = 1'b1; rdy_c40 = 1'b1; rdy_c42 = 1'b0; tx_end = 1'b0; st_end = 1'b1;
        @(negedge clk);
        ld0 = 1'b1; d0 = 8'h01;
        for (int c = 0; c <= 201; c++) begin
            @(negedge clk);
            if (c < 5) d0 = 8'(c + 2);
            else ld0 = 1'b0;
            if (ov0 === 1'b1) begin ovf_n++; ovf_at = c; end
            if (int'(cnt0) > peak) peak = int'(cnt0);
            if (c == 0) tx_c0 = tx0;
            else if (c <= 200 && tx0 !== stream[(c - 1) / CPB]) mism++;
            if (c <= 200 && st0 !== 1'b1) st_low++;
            if (c == 4)   rdy_c4  = rdy0;
            if (c == 40)  rdy_c40 = rdy0;
            if (c == 42)  rdy_c42 = rdy0;
            if (c == 201) begin tx_end = tx0; st_end = st0; end
        end
        chk("b2b idle at first load", 32'(tx_c0), 32'd1);
        chk("b2b stream bits", 32'(mism), 32'd0);
        chk("b2b overflow pulses", 32'(ovf_n), 32'd1);
        chk("b2b overflow cycle", 32'(ovf_at), 32'd5);
        chk("b2b peak count", 32'(peak), 32'd4);
        chk("b2b ready when full", 32'(rdy_c4), 32'd0);
        chk("b2b ready before pop", 32'(rdy_c40), 32'd0);
        chk("b2b ready after pop", 32'(rdy_c42), 32'd1);
        chk("b2b status continuous", 32'(st_low), 32'd0);
        chk("b2b idle at end", 32'(tx_end), 32'd1);
        chk("b2b status at end", 32'(st_end), 32'd0);
        chk("b2b count at end", 32'(cnt0), 32'd0);

        // Reset during data bit 3 (0x11 bit 3 = 0) with two entries queued.
        @(negedge clk);
        ld0 = 1'b1; d0 = 8'h11;
        for (int c = 0; c <= 18; c++) begin
            @(negedge clk);
            if (c == 0) d0 = 8'h22;
            else if (c == 1) d0 = 8'h33;
            else ld0 = 1'b0;
        end
        chk("pre-rst queued", 32'(cnt0), 32'd2);
        chk("pre-rst data bit3", 32'(tx0), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid-rst tx_out", 32'(tx0), 32'd1);
        chk("mid-rst fifo_count", 32'(cnt0), 32'd0);
        chk("mid-rst tx_status", 32'(st0), 32'd0);
        chk("mid-rst ready", 32'(rdy0), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        send(0, 9'h03C); check_frame("post-rst 3C", 16'({1'b1, 8'h3C, 1'b0}), 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO and per-frame bit timing. It replaces the fixed 8N1 transmitter and separate baud-clock pairing: one system clock drives everything, and bit timing comes from a divide count. Width, parity, stop bits and FIFO depth are set by parameters. The block sits between a byte producer and the serial line `tx_out`.

## Interface
- `CLKS_PER_BIT`, default 868: `clk` cycles per serial bit; ≥ 2.
- `DATA_BITS`, default 8: payload bits per frame; 5..9.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `FIFO_DEPTH`, default 4: entries; power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; one clock domain, rising edge only.
- `rst`  in  1  synchronous, active-high reset.
- `d_in`  in  DATA_BITS  parallel data, sampled when `load` is accepted.
- `load`  in  1  write strobe; accepted on an edge where `load && ready`.
- `ready`  out  1  FIFO not full (registered).
- `tx_out`  out  1  serial line; idle high.
- `tx_status`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `overflow`  out  1  one-cycle pulse when `load` is high and `ready` is low; the data is dropped.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  occupied entries.

## Operation
- Frame format:
  - start bit (0);
  - DATA_BITS payload bits, LSB first;
  - parity bit if PARITY≠0 (even: XOR of the data; odd: its inverse);
  - STOP_BITS stop bits (1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. On that edge, pop the head into the shift register and drive `tx_out` = 0.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY (or STOP if PARITY=0) after DATA_BITS bit periods.
  - PARITY → STOP after one bit period.
  - At the end of the last stop bit: if the FIFO is non-empty, pop and go straight to START (zero idle gap). Otherwise go to IDLE.
- Bit timer: counts 0..CLKS_PER_BIT-1 and restarts at every frame start. It is aligned to the frame, not free-running.
- Bit index counter: counts 0..DATA_BITS-1. Stop counter: counts 0..STOP_BITS-1.
- FIFO:
  - Circular buffer with read and write pointers that wrap modulo FIFO_DEPTH.
  - Push and pop in the same cycle leave `fifo_count` unchanged.
  - When full, a push is rejected even if a pop happens on the same edge. `ready` reflects only the registered count.
- Parity is computed from the popped word when it is loaded into the shift register.
- Reset values: `tx_out`=1, `tx_status`=0, `ready`=1, `overflow`=0, `fifo_count`=0, state IDLE, all counters 0.
- Reset mid-frame aborts the frame and flushes the FIFO. `tx_out` is 1 from the edge that samples `rst` onward.
- A `load` on the same edge as `rst` is ignored.

## Timing
- Load sampled at edge k → entry written at k → popped at k+1 → `tx_out` low from k+1. Latency is 1 cycle from an idle, empty state.
- Frame length = (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles exactly. Each bit holds for exactly CLKS_PER_BIT cycles.
- `tx_status` rises at edge k (when the write makes the FIFO non-empty). It falls at the edge that ends the last stop bit with the FIFO empty.
- `ready` falls on the edge where `fifo_count` reaches FIFO_DEPTH. It rises on the edge after the pop that makes room.
- `overflow` is registered and high for exactly one cycle after the rejected edge.
- All outputs are registered; no combinational path from input to output.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_tx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - parity constants `PAR_NONE`, `PAR_EVEN`, `PAR_ODD`.
- Sub-module `uart_tx_fifo_mem`: the parametrised synchronous FIFO, with push, pop, full, empty and count. The top level contains the FSM, bit timer, shift register and parity logic.

## Test plan
- Reset: hold `rst` 3 cycles → `tx_out`=1, `tx_status`=0, `ready`=1, `fifo_count`=0, `overflow`=0.
- CLKS_PER_BIT=4, 8N1: load 8'hA5 → `tx_out` holds 0,1,0,1,0,0,1,0,1,1, each for 4 cycles (40 cycles total); `tx_status` is high for the whole 40 cycles; first low bit at k+1.
- PARITY=1 then PARITY=2, load 8'h07 → parity bit is 1 (even) and 0 (odd); frame is 44 cycles at CLKS_PER_BIT=4.
- FIFO_DEPTH=4: `load` high on 6 consecutive edges with data 01..06 → first 5 accepted, sixth dropped. `overflow` pulses once, `fifo_count` peaks at 4, and 5 frames go out back-to-back with no idle cycle.
- Reset mid-frame: assert `rst` during data bit 3 with 2 entries queued → `tx_out`=1 and `fifo_count`=0 after the reset edge. A later load of 8'h3C produces one clean frame.
- DATA_BITS=7, STOP_BITS=2, PARITY=0: load 7'h55 → 10 bit periods, with the last 2 high.
